// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: binary-search acquisition of the DCO word, incremental tracking, hysteretic lock.
// Optional macro ADPLL_FAST_TRACK_EN adds a coarse tracking gear (step 4 when |err| > 2).
module adpll_loop_ctrl #(
   parameter int M_W        = 3,
   parameter int CODE_W     = 8,
   parameter int CNT_W      = 8,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4,
   parameter int TOL        = 1
) (
   input  logic              REF_CLK,
   input  logic              RESET,
   input  logic [M_W-1:0]    M,
   input  logic [CNT_W-1:0]  CNT_IN,
   input  logic              CNT_VALID,
   output logic [CODE_W-1:0] DCO_CODE,
   output logic              LOCK,
   output logic [1:0]        STATE
);

   localparam int ERR_W  = CNT_W + 2;
   localparam int SC_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
   localparam int SC_W   = $clog2(SC_MAX + 1);
   localparam int IDX_W  = (CODE_W > 1) ? $clog2(CODE_W) : 1;

   localparam logic [CODE_W-1:0] CODE_MID = CODE_W'(1) << (CODE_W - 1);
   localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(CODE_W - 1);
   localparam logic [SC_W-1:0]   LOCK_LIM = SC_W'(LOCK_CNT);
   localparam logic [SC_W-1:0]   MISS_LIM = SC_W'(UNLOCK_CNT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_TRACK  = 2'd2
   } state_t;

   state_t                state_p0;
   logic [CODE_W-1:0]     code_p0;
   logic                  lock_p0;
   logic [IDX_W-1:0]      idx_p0;
   logic [M_W-1:0]        m_p0;
   logic [SC_W-1:0]       lock_cnt_p0;
   logic [SC_W-1:0]       miss_cnt_p0;

   logic [M_W:0]          n_val;
   logic signed [ERR_W-1:0] err;
   logic [ERR_W-1:0]      err_mag;
   logic                  err_pos;
   logic                  err_neg;
   logic                  in_win;
   logic [2:0]            track_step;
   logic [CODE_W-1:0]     srch_code;
   logic [SC_W-1:0]       lock_inc;
   logic [SC_W-1:0]       miss_inc;

   // Moves code by step toward up/down, clamping at both ends of the code range.
   function automatic logic [CODE_W-1:0] sat_step(input logic [CODE_W-1:0] code,
                                                  input logic              dn,
                                                  input logic [2:0]        step);
      logic signed [CODE_W+1:0] delta;
      logic signed [CODE_W+1:0] sum;
      delta = $signed({{(CODE_W-1){1'b0}}, step});
      if (dn)
         delta = -delta;
      sum = $signed({2'b00, code}) + delta;
      if (sum[CODE_W+1])
         return '0;
      else if (sum[CODE_W])
         return '1;
      else
         return sum[CODE_W-1:0];
   endfunction

   function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] c,
                                               input logic [SC_W-1:0] lim);
      return (c >= lim) ? lim : c + SC_W'(1);
   endfunction

   assign n_val   = {1'b0, m_p0} + {{M_W{1'b0}}, 1'b1};
   assign err     = $signed({2'b00, CNT_IN}) - $signed(ERR_W'(n_val));
   assign err_neg = err[ERR_W-1];
   assign err_pos = !err[ERR_W-1] && (err != '0);
   assign err_mag = err_neg ? ERR_W'(-err) : ERR_W'(err);
   assign in_win  = (err_mag <= ERR_W'(TOL));

`ifdef ADPLL_FAST_TRACK_EN
   assign track_step = (err_mag > ERR_W'(2)) ? 3'd4 : 3'd1;
`else
   assign track_step = 3'd1;
`endif

   assign lock_inc = sat_inc(lock_cnt_p0, LOCK_LIM);
   assign miss_inc = sat_inc(miss_cnt_p0, MISS_LIM);

   // Resolve the current bit (too fast -> drop it) and trial-set the next lower bit.
   always_comb begin
      srch_code = code_p0;
      if (err_pos)
         srch_code[idx_p0] = 1'b0;
      if (idx_p0 != '0)
         srch_code[idx_p0 - IDX_W'(1)] = 1'b1;
   end

   always_ff @(posedge REF_CLK or negedge RESET) begin
      if (!RESET) begin
         state_p0    <= ST_IDLE;
         code_p0     <= CODE_MID;
         lock_p0     <= 1'b0;
         idx_p0      <= IDX_TOP;
         m_p0        <= '0;
         lock_cnt_p0 <= '0;
         miss_cnt_p0 <= '0;
      end else if (state_p0 == ST_IDLE || M != m_p0) begin
         // A new ratio invalidates everything learned so far; any sample this cycle is dropped.
         m_p0        <= M;
         state_p0    <= ST_SEARCH;
         code_p0     <= CODE_MID;
         idx_p0      <= IDX_TOP;
         lock_p0     <= 1'b0;
         lock_cnt_p0 <= '0;
         miss_cnt_p0 <= '0;
      end else if (CNT_VALID) begin
         case (state_p0)
            ST_SEARCH: begin
               code_p0 <= srch_code;
               if (idx_p0 == '0)
                  state_p0 <= ST_TRACK;
               else
                  idx_p0 <= idx_p0 - IDX_W'(1);
            end
            ST_TRACK: begin
               if (err_pos)
                  code_p0 <= sat_step(code_p0, 1'b1, track_step);
               else if (err_neg)
                  code_p0 <= sat_step(code_p0, 1'b0, track_step);
               if (in_win) begin
                  miss_cnt_p0 <= '0;
                  lock_cnt_p0 <= lock_inc;
                  if (lock_inc == LOCK_LIM)
                     lock_p0 <= 1'b1;
               end else begin
                  lock_cnt_p0 <= '0;
                  miss_cnt_p0 <= miss_inc;
                  if (miss_inc == MISS_LIM)
                     lock_p0 <= 1'b0;
               end
            end
            default: state_p0 <= ST_IDLE;
         endcase
      end
   end

   assign DCO_CODE = code_p0;
   assign LOCK     = lock_p0;
   assign STATE    = state_p0;

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Scoreboard bench for adpll_loop_ctrl: directed samples push expected results, a monitor pops and compares.
module tb_adpll_loop_ctrl;

   typedef struct {
      logic [7:0] code;
      logic       lock;
      logic [1:0] state;
      string      name;
   } exp_t;

   logic       ref_clk = 1'b0;
   logic       reset;
   logic [2:0] m;
   logic [7:0] cnt_in;
   logic       cnt_valid;
   logic [7:0] dco_code;
   logic       lock;
   logic [1:0] state;

   logic       chk = 1'b0;
   logic       obs_vld = 1'b0;
   exp_t       exp_q[$];
   exp_t       cur;
   int         n_checks = 0;
   int         n_fail = 0;

   logic [7:0] srch_a [8] = '{8'hC0, 8'hA0, 8'h90, 8'h98, 8'h9C, 8'h9E, 8'h9F, 8'h9F};
   logic [7:0] srch_s [8] = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF};

`ifdef ADPLL_FAST_TRACK_EN
   localparam logic [7:0] BIG_STEP = 8'd4;
`else
   localparam logic [7:0] BIG_STEP = 8'd1;
`endif

   adpll_loop_ctrl dut (
      .REF_CLK  (ref_clk),
      .RESET    (reset),
      .M        (m),
      .CNT_IN   (cnt_in),
      .CNT_VALID(cnt_valid),
      .DCO_CODE (dco_code),
      .LOCK     (lock),
      .STATE    (state)
   );

   always #5 ref_clk = ~ref_clk;

   always @(posedge ref_clk) obs_vld <= cnt_valid | chk;

   always @(negedge ref_clk) begin
      if (obs_vld) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got code=%h lock=%b state=%0d, no expectation queued",
                     dco_code, lock, state);
         end else begin
            cur = exp_q.pop_front();
            if (dco_code !== cur.code || lock !== cur.lock || state !== cur.state) begin
               n_fail++;
               $display("FAIL %s: got code=%h lock=%b state=%0d, expected code=%h lock=%b state=%0d",
                        cur.name, dco_code, lock, state, cur.code, cur.lock, cur.state);
            end
         end
      end
   end

   task automatic step(input logic v, input logic [7:0] cin, input logic c,
                       input logic [2:0] mv, input logic rv,
                       input logic [7:0] ecode, input logic elock, input logic [1:0] est,
                       input string nm);
      exp_t e;
      @(posedge ref_clk);
      #1;
      cnt_valid = v;
      cnt_in    = cin;
      chk       = c;
      m         = mv;
      reset     = rv;
      if (v || c) begin
         e.code  = ecode;
         e.lock  = elock;
         e.state = est;
         e.name  = nm;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input logic [2:0] mv);
      step(1'b0, 8'd0, 1'b0, mv, 1'b1, 8'd0, 1'b0, 2'd0, "");
   endtask

   task automatic search_m3();
      logic [7:0] prev;
      prev = 8'h80;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, prev >> 5, 1'b0, 3'd3, 1'b1, srch_a[i], 1'b0,
              (i == 7) ? 2'd2 : 2'd1, "search_m3");
         idle(3'd3);
         prev = srch_a[i];
      end
   endtask

   initial begin
      logic [7:0] uc;
      reset = 1'b0; m = 3'd3; cnt_in = 8'd0; cnt_valid = 1'b0;

      step(1'b0, 8'd0, 1'b1, 3'd3, 1'b0, 8'h80, 1'b0, 2'd0, "reset_hold");
      step(1'b0, 8'd0, 1'b1, 3'd3, 1'b1, 8'h80, 1'b0, 2'd1, "idle_to_search");
      idle(3'd3);
      search_m3();

      // Out-of-window sample from 0x9F: gear depends on build
      step(1'b1, 8'd7, 1'b0, 3'd3, 1'b1, 8'h9F - BIG_STEP, 1'b0, 2'd2, "track_err3");
      idle(3'd3);

      step(1'b0, 8'd0, 1'b1, 3'd3, 1'b0, 8'h80, 1'b0, 2'd0, "reset_mid_track");
      step(1'b0, 8'd0, 1'b1, 3'd3, 1'b1, 8'h80, 1'b0, 2'd1, "rerelease");
      idle(3'd3);
      search_m3();

      // err=+1 is in-window and steps by one in both builds
      step(1'b1, 8'd5, 1'b0, 3'd3, 1'b1, 8'h9E, 1'b0, 2'd2, "track_err1");
      for (int i = 0; i < 16; i++)
         step(1'b1, 8'd4, 1'b0, 3'd3, 1'b1, 8'h9E, (i >= 14), 2'd2, "lock_acquire");
      idle(3'd3);

      uc = 8'h9E;
      for (int i = 0; i < 4; i++) begin
         uc = uc - BIG_STEP;
         step(1'b1, 8'd7, 1'b0, 3'd3, 1'b1, uc, (i != 3), 2'd2, "unlock");
      end
      idle(3'd3);

      for (int i = 0; i < 16; i++)
         step(1'b1, 8'd4, 1'b0, 3'd3, 1'b1, uc, (i == 15), 2'd2, "relock");
      idle(3'd3);

      step(1'b1, 8'd0, 1'b0, 3'd5, 1'b1, 8'h80, 1'b0, 2'd1, "m_change");
      idle(3'd5);

      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8'd0, 1'b0, 3'd5, 1'b1, srch_s[i], 1'b0,
              (i == 7) ? 2'd2 : 2'd1, "search_sat");
         idle(3'd5);
      end
      for (int i = 0; i < 5; i++)
         step(1'b1, 8'd0, 1'b0, 3'd5, 1'b1, 8'hFF, 1'b0, 2'd2, "track_sat");
      idle(3'd5);
      idle(3'd5);
      idle(3'd5);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
